// File: rtl/pcihellocore_button_irq_pio_if.sv
// Avalon-MM slave bus bundle for the push-button PIO: word address, strobes and
// registered read data.
interface pcihellocore_button_irq_pio_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic        read_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, read_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, read_n, writedata,
      output readdata
   );
endinterface

// File: rtl/pcihellocore_button_irq_pio.sv
// Push-button PIO: synchronised inputs, sticky edge capture, maskable level irq, output port.
// Optional per-channel debounce filter enabled by defining PCIHELLOCORE_BUTTON_DEBOUNCE_EN.
module pcihellocore_button_irq_pio #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned EDGE_TYPE       = 1,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   pcihellocore_button_irq_pio_if.slave bus,
   input  logic [WIDTH-1:0]             in_port,
   output logic [WIDTH-1:0]             out_port,
   output logic                         irq
);

   logic [WIDTH-1:0] s1_q, s2_q, filt, prev_q;
   logic [WIDTH-1:0] edge_cap_q, edge_cap_d, irq_mask_q, out_q;
   logic [WIDTH-1:0] rise, fall, evt, clr;
   logic [1:0]       arm_q;
   logic [31:0]      readdata_q, rd_mux;
   logic             irq_q, wr_en, rd_en, armed;

   assign wr_en = bus.chipselect & ~bus.write_n;
   assign rd_en = bus.chipselect & ~bus.read_n;
   assign armed = (arm_q == 2'd3);

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= in_port;
         s2_q <= s1_q;
      end
   end

`ifdef PCIHELLOCORE_BUTTON_DEBOUNCE_EN
   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);

   logic [CntW-1:0]  cnt_q [WIDTH];
   logic [WIDTH-1:0] filt_q;

   // A channel follows s2 only after it has disagreed for DEBOUNCE_CYCLES edges in a row.
   always_ff @(posedge clk) begin
      if (reset) begin
         filt_q <= '0;
         for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            if (s2_q[i] != filt_q[i]) begin
               if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
                  filt_q[i] <= s2_q[i];
                  cnt_q[i]  <= '0;
               end else begin
                  cnt_q[i]  <= cnt_q[i] + CntW'(1);
               end
            end else begin
               cnt_q[i] <= '0;
            end
         end
      end
   end

   assign filt = filt_q;
`else
   assign filt = s2_q;
`endif

   always_comb begin
      rise = filt & ~prev_q;
      fall = ~filt & prev_q;
      case (EDGE_TYPE)
         0:       evt = rise;
         1:       evt = fall;
         default: evt = rise | fall;
      endcase
      clr = (wr_en && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : '0;
      // Set dominates a coincident write-1-to-clear on the same bit.
      edge_cap_d = (edge_cap_q & ~clr) | (armed ? evt : '0);
   end

   always_comb begin
      rd_mux = '0;
      case (bus.address)
         2'd0:    rd_mux = 32'(filt);
         2'd1:    rd_mux = 32'(irq_mask_q);
         2'd2:    rd_mux = 32'(edge_cap_q);
         default: rd_mux = 32'(out_q);
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q     <= '0;
         arm_q      <= '0;
         edge_cap_q <= '0;
         irq_mask_q <= '0;
         out_q      <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         prev_q     <= filt;
         edge_cap_q <= edge_cap_d;
         irq_q      <= |(edge_cap_q & irq_mask_q);
         if (!armed) arm_q <= arm_q + 2'd1;
         if (rd_en) readdata_q <= rd_mux;
         if (wr_en && bus.address == 2'd0) out_q      <= bus.writedata[WIDTH-1:0];
         if (wr_en && bus.address == 2'd1) irq_mask_q <= bus.writedata[WIDTH-1:0];
      end
   end

   assign bus.readdata = readdata_q;
   assign out_port     = out_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_pcihellocore_button_irq_pio.sv
// Self-checking bench for pcihellocore_button_irq_pio: directed scenarios plus random
// traffic, checked every cycle against a history-based reference model.
module tb_pcihellocore_button_irq_pio;

   localparam int unsigned Width          = 4;
   localparam int unsigned EdgeType       = 1;
   localparam int unsigned DebounceCycles = 16;
`ifdef PCIHELLOCORE_BUTTON_DEBOUNCE_EN
   localparam int Lat = DebounceCycles;
`else
   localparam int Lat = 0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [Width-1:0] in_port, out_port;
   logic             irq;

   pcihellocore_button_irq_pio_if bus_if ();

   pcihellocore_button_irq_pio #(
      .WIDTH           (Width),
      .EDGE_TYPE       (EdgeType),
      .DEBOUNCE_CYCLES (DebounceCycles)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus_if),
      .in_port  (in_port),
      .out_port (out_port),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: in_port history indexed by clock edge, plus architectural registers.
   int         edge_k   = 0;
   int         rst_edge = 0;
   logic [3:0] hist [0:8191];
   logic [3:0] m_filt, m_prev, m_cap, m_mask, m_out;
   logic       m_irq;
   logic [31:0] m_rd;
   int         run [4];

   function automatic logic [3:0] hist_at(input int j);
      if (j <= rst_edge) return 4'h0;
      return hist[j];
   endfunction

   task automatic model_step();
      logic [3:0] ev, clr, nxt_cap;
      logic       wr, rd, armed;
      edge_k++;
      hist[edge_k] = in_port;
      if (reset) begin
         rst_edge = edge_k;
         m_filt = '0; m_prev = '0; m_cap = '0; m_mask = '0; m_out = '0;
         m_irq = 1'b0; m_rd = '0;
         for (int b = 0; b < 4; b++) run[b] = 0;
      end else begin
         wr    = bus_if.chipselect && !bus_if.write_n;
         rd    = bus_if.chipselect && !bus_if.read_n;
         armed = (edge_k - 1 - rst_edge) >= 3;
         case (EdgeType)
            0:       ev = m_filt & ~m_prev;
            1:       ev = ~m_filt & m_prev;
            default: ev = m_filt ^ m_prev;
         endcase
         if (rd) begin
            case (bus_if.address)
               2'd0:    m_rd = {28'h0, m_filt};
               2'd1:    m_rd = {28'h0, m_mask};
               2'd2:    m_rd = {28'h0, m_cap};
               default: m_rd = {28'h0, m_out};
            endcase
         end
         clr     = (wr && bus_if.address == 2'd2) ? bus_if.writedata[3:0] : 4'h0;
         nxt_cap = (m_cap & ~clr) | (armed ? ev : 4'h0);
         m_irq   = |(m_cap & m_mask);
         if (wr && bus_if.address == 2'd0) m_out  = bus_if.writedata[3:0];
         if (wr && bus_if.address == 2'd1) m_mask = bus_if.writedata[3:0];
         m_cap  = nxt_cap;
         m_prev = m_filt;
`ifdef PCIHELLOCORE_BUTTON_DEBOUNCE_EN
         // A bit follows the synchronised input once it has disagreed for DebounceCycles edges.
         for (int b = 0; b < 4; b++) begin
            if (hist_at(edge_k - 2)[b] != m_prev[b]) begin
               run[b]++;
               if (run[b] == int'(DebounceCycles)) begin
                  m_filt[b] = hist_at(edge_k - 2)[b];
                  run[b]    = 0;
               end
            end else begin
               run[b] = 0;
            end
         end
`else
         m_filt = hist_at(edge_k - 1);
`endif
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_eq("readdata", bus_if.readdata, m_rd);
      check_eq("irq", 32'(irq), 32'(m_irq));
      check_eq("out_port", 32'(out_port), 32'(m_out));
   endtask

   task automatic bus_idle();
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.read_n     = 1'b1;
      bus_if.address    = 2'd0;
      bus_if.writedata  = '0;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      bus_if.address    = a;
      bus_if.writedata  = d;
      cyc();
      bus_idle();
   endtask

   task automatic do_read(input logic [1:0] a, output logic [31:0] d);
      bus_if.chipselect = 1'b1;
      bus_if.read_n     = 1'b0;
      bus_if.address    = a;
      cyc();
      d = bus_if.readdata;
      bus_idle();
   endtask

   initial begin
      logic [31:0] d;
      bus_idle();
      reset   = 1'b1;
      in_port = 4'hF;
      repeat (2) cyc();
      check_eq("rst_irq", 32'(irq), 32'h0);
      check_eq("rst_readdata", bus_if.readdata, 32'h0);
      check_eq("rst_out", 32'(out_port), 32'h0);
      reset = 1'b0;

      // Inputs high across reset release must not capture.
      repeat (10 + Lat) cyc();
      do_read(2'd2, d);
      check_eq("idle_cap", d, 32'h0);
      check_eq("idle_irq", 32'(irq), 32'h0);
      do_read(2'd0, d);
      check_eq("idle_data", d, 32'h0000_000F);

      // Masked falling edge on bit 1 -> irq, then W1C clears it.
      do_write(2'd1, 32'h2);
      in_port = 4'hD;
      repeat (3 + Lat) cyc();
      check_eq("irq_pre", 32'(irq), 32'h0);
      cyc();
      check_eq("irq_fall", 32'(irq), 32'h1);
      do_read(2'd2, d);
      check_eq("cap_fall", d, 32'h2);
      do_write(2'd2, 32'h2);
      check_eq("irq_hold", 32'(irq), 32'h1);
      cyc();
      check_eq("irq_clr", 32'(irq), 32'h0);

      // Capture while masked, then unmask.
      do_write(2'd1, 32'h0);
      in_port = 4'hC;
      repeat (4 + Lat) cyc();
      do_read(2'd2, d);
      check_eq("cap_masked", d, 32'h1);
      check_eq("irq_masked", 32'(irq), 32'h0);
      do_write(2'd1, 32'h1);
      cyc();
      check_eq("irq_unmask", 32'(irq), 32'h1);

      // Coincident capture and clear on bit 0: set wins.
      in_port = 4'hF;
      repeat (4 + Lat) cyc();
      do_write(2'd2, 32'h1);
      cyc();
      in_port = 4'hE;
      repeat (2 + Lat) cyc();
      do_write(2'd2, 32'h1);
      cyc();
      do_read(2'd2, d);
      check_eq("set_wins", d, 32'h1);

      // Upper write bits ignored; readback on address 3.
      do_write(2'd0, 32'hFFFF_FFF5);
      check_eq("out_low", 32'(out_port), 32'h5);
      do_read(2'd3, d);
      check_eq("out_rb", d, 32'h5);

`ifdef PCIHELLOCORE_BUTTON_DEBOUNCE_EN
      in_port = 4'hF;
      repeat (4 + Lat) cyc();
      do_write(2'd2, 32'hF);
      in_port = 4'hB;
      repeat (10) cyc();
      in_port = 4'hF;
      repeat (30) cyc();
      do_read(2'd2, d);
      check_eq("db_glitch", d, 32'h0);
      in_port = 4'hB;
      repeat (40) cyc();
      do_read(2'd2, d);
      check_eq("db_cap", d, 32'h4);
      in_port = 4'hF;
      repeat (20) cyc();
`endif

      // Random traffic against the model, with occasional mid-run resets.
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 11) == 0) in_port = 4'($urandom);
         reset             = ($urandom_range(0, 299) == 0);
         bus_if.chipselect = ($urandom_range(0, 3) != 0);
         bus_if.write_n    = ($urandom_range(0, 2) != 0);
         bus_if.read_n     = ($urandom_range(0, 1) != 0);
         bus_if.address    = 2'($urandom_range(0, 3));
         bus_if.writedata  = $urandom;
         cyc();
      end
      reset = 1'b0;
      bus_idle();
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
